fft_stage_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIT FFT over a single shared butterfly datapath (FFT_Calc pair) and a sync-read sample RAM.
//  Per stage, issues one butterfly per cycle: RAM read addresses, twiddle index, delayed write-back addresses/enables.

---
 rtl/fft_stage_sequencer_pkg.sv | 39 +++
 rtl/fft_stage_sequencer_if.sv | 33 +++
 rtl/fft_stage_sequencer_addr_gen.sv | 30 +++
 rtl/fft_stage_sequencer.sv | 141 ++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and helpers for the radix-2 in-place FFT stage sequencer:
// FSM state encoding, default sizing and the butterfly address function.
package fft_stage_sequencer_pkg;

  localparam int FFT_POINTS_DEF = 32;
  localparam int PIPE_LAT_DEF   = 3;
  localparam int BFLY_W         = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fft_seq_state_e;

  typedef struct packed {
    logic [BFLY_W-1:0] a;
    logic [BFLY_W-1:0] b;
    logic [BFLY_W-1:0] tw;
  } bfly_addr_t;

  // Butterfly k of stage s: the even/odd legs sit span apart inside group grp.
  function automatic bfly_addr_t bfly_addr(input logic [7:0]        s,
                                           input logic [BFLY_W-1:0] k,
                                           input logic [7:0]        log2n);
    logic [BFLY_W-1:0] span;
    logic [BFLY_W-1:0] pos;
    logic [BFLY_W-1:0] grp;
    bfly_addr_t        r;
    span = BFLY_W'(1) << s;
    pos  = k & (span - BFLY_W'(1));
    grp  = k >> s;
    r.a  = (grp << (s + 8'd1)) | pos;
    r.b  = r.a + span;
    r.tw = pos << (log2n - 8'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Control/address bus between the frame-buffer controller, the FFT stage
// sequencer and the butterfly datapath / sample RAM.
interface fft_stage_sequencer_if
  import fft_stage_sequencer_pkg::*;
#(
  parameter int ADDR_W  = $clog2(FFT_POINTS_DEF),
  parameter int STAGE_W = $clog2(ADDR_W + 1)
);
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [STAGE_W-1:0] stage;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr_a;
  logic [ADDR_W-1:0]  rd_addr_b;
  logic [ADDR_W-2:0]  twiddle_idx;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr_a;
  logic [ADDR_W-1:0]  wr_addr_b;

  modport master (
    output start, abort,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, twiddle_idx,
           wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input  start, abort,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, twiddle_idx,
           wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/fft_stage_sequencer_addr_gen.sv
// Combinational (stage, k) -> (even address, odd address, twiddle index)
// for an in-place radix-2 DIT butterfly.
module fft_stage_sequencer_addr_gen
  import fft_stage_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int STAGE_W = 3
) (
  input  logic [STAGE_W-1:0] stage_i,
  input  logic [ADDR_W-2:0]  k_i,
  output logic [ADDR_W-1:0]  rd_addr_a_o,
  output logic [ADDR_W-1:0]  rd_addr_b_o,
  output logic [ADDR_W-2:0]  twiddle_idx_o
);

  bfly_addr_t res;
  logic       unused_hi;

  always_comb begin
    res           = bfly_addr(8'(stage_i), BFLY_W'(k_i), 8'(ADDR_W));
    rd_addr_a_o   = res.a[ADDR_W-1:0];
    rd_addr_b_o   = res.b[ADDR_W-1:0];
    twiddle_idx_o = res.tw[ADDR_W-2:0];
  end

  // Upper bits are always zero for legal (stage, k); kept only for width.
  assign unused_hi = ^{res.a[BFLY_W-1:ADDR_W], res.b[BFLY_W-1:ADDR_W],
                       res.tw[BFLY_W-1:ADDR_W-1]};

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequences an in-place radix-2 DIT FFT over one shared butterfly: one read
// pair per cycle, write-back addresses delayed by the datapath latency.
module fft_stage_sequencer
  import fft_stage_sequencer_pkg::*;
#(
  parameter int FFT_POINTS = FFT_POINTS_DEF,
  parameter int ADDR_W     = $clog2(FFT_POINTS),
  parameter int STAGE_W    = $clog2(ADDR_W + 1),
  parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  fft_stage_sequencer_if.slave bus
);

  localparam int                 CNT_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDR_W-2:0]  K_LAST     = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PIPE_LAT - 1);

  fft_seq_state_e     state_q, state_d;
  logic [ADDR_W-2:0]  k_q, k_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               rd_en;
  logic               flush;
  logic [ADDR_W-1:0]  gen_a;
  logic [ADDR_W-1:0]  gen_b;
  logic [ADDR_W-2:0]  gen_tw;

  logic [PIPE_LAT-1:0] vld_q;
  logic [ADDR_W-1:0]   wb_a_q [PIPE_LAT];
  logic [ADDR_W-1:0]   wb_b_q [PIPE_LAT];

  fft_stage_sequencer_addr_gen #(
    .ADDR_W  (ADDR_W),
    .STAGE_W (STAGE_W)
  ) u_addr_gen (
    .stage_i       (stage_q),
    .k_i           (k_q),
    .rd_addr_a_o   (gen_a),
    .rd_addr_b_o   (gen_b),
    .twiddle_idx_o (gen_tw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        k_d     = '0;
        stage_d = '0;
        cnt_d   = '0;
        if (bus.start && !bus.abort) state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + (ADDR_W-1)'(1);
        end
      end
      // The stage's last write lands in the final drain cycle, so the next
      // stage may read the following cycle without a read-after-write hazard.
      DRAIN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      k_d     = '0;
      stage_d = '0;
      cnt_d   = '0;
    end
  end

  assign rd_en = (state_q == RUN);
  assign flush = bus.abort && (state_q != IDLE);

  // ---- write-back delay line: valid is control, addresses are data ----
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= rd_en;
      for (int i = 1; i < PIPE_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    wb_a_q[0] <= gen_a;
    wb_b_q[0] <= gen_b;
    for (int i = 1; i < PIPE_LAT; i++) begin
      wb_a_q[i] <= wb_a_q[i-1];
      wb_b_q[i] <= wb_b_q[i-1];
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.stage       = stage_q;
  assign bus.rd_en       = rd_en;
  assign bus.rd_addr_a   = rd_en ? gen_a : '0;
  assign bus.rd_addr_b   = rd_en ? gen_b : '0;
  assign bus.twiddle_idx = rd_en ? gen_tw : '0;
  assign bus.wr_en       = vld_q[PIPE_LAT-1];
  assign bus.wr_addr_a   = vld_q[PIPE_LAT-1] ? wb_a_q[PIPE_LAT-1] : '0;
  assign bus.wr_addr_b   = vld_q[PIPE_LAT-1] ? wb_b_q[PIPE_LAT-1] : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: an N=8 instance against directed
// address tables and an N=32 instance driving a floating-point RAM model.
module tb_fft_stage_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_on = 1'b0;

  fft_stage_sequencer_if #(.ADDR_W(3), .STAGE_W(2)) if8 ();
  fft_stage_sequencer_if #(.ADDR_W(5), .STAGE_W(3)) if32 ();

  fft_stage_sequencer #(.FFT_POINTS(8), .ADDR_W(3), .STAGE_W(2), .PIPE_LAT(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  fft_stage_sequencer #(.FFT_POINTS(32), .ADDR_W(5), .STAGE_W(3), .PIPE_LAT(3)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  typedef struct packed {
    int cyc;
    int addr;
  } exp_t;

  exp_t q8_rd[$];
  exp_t q8_wr[$];
  int   q8_done[$];
  int   q32_done[$];

  // N=8 hand-derived butterfly table, offsets relative to the start cycle
  int t8_off[12] = '{1, 2, 3, 4, 8, 9, 10, 11, 15, 16, 17, 18};
  int t8_a[12]   = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int t8_b[12]   = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int t8_tw[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  real re[32];
  real im[32];
  real p_sr[$], p_si[$], p_dr[$], p_di[$];
  real m_ang, m_wr, m_wi, m_tr, m_ti;
  int  c32_rd = 0;
  int  c32_wr = 0;
  exp_t m8_e;

  function automatic int pack(input int a, input int b, input int tw, input int st);
    return a * 1000000 + b * 10000 + tw * 100 + st;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act !== expv) $display("FAIL %s: got %0d expected %0d", name, act, expv);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic ram_impulse();
    for (int i = 0; i < 32; i++) begin
      re[i] = 0.0;
      im[i] = 0.0;
    end
    re[0] = 1.0;
  endtask

  task automatic check_bins();
    int nbad;
    nbad = 0;
    for (int i = 0; i < 32; i++)
      if (re[i] > 1.000001 || re[i] < 0.999999 || im[i] > 0.000001 || im[i] < -0.000001)
        nbad++;
    chk("d32_impulse_bins_bad", nbad, 0);
  endtask

  // ---- N=8 monitor ----
  always @(negedge clk) begin
    if (mon_on) begin
      if (if8.rd_en) begin
        if (q8_rd.size() == 0) chk("d8_rd_unexpected", cyc, -1);
        else begin
          m8_e = q8_rd.pop_front();
          chk("d8_rd_cycle", cyc, m8_e.cyc);
          chk("d8_rd_addr", pack(int'(if8.rd_addr_a), int'(if8.rd_addr_b),
                                 int'(if8.twiddle_idx), int'(if8.stage)), m8_e.addr);
        end
      end
      if (if8.wr_en) begin
        if (q8_wr.size() == 0) chk("d8_wr_unexpected", cyc, -1);
        else begin
          m8_e = q8_wr.pop_front();
          chk("d8_wr_cycle", cyc, m8_e.cyc);
          chk("d8_wr_addr", pack(int'(if8.wr_addr_a), int'(if8.wr_addr_b), 0, 0), m8_e.addr);
        end
      end
      if (if8.done) begin
        if (q8_done.size() == 0) chk("d8_done_unexpected", cyc, -1);
        else chk("d8_done_cycle", cyc, q8_done.pop_front());
      end
    end
  end

  // ---- N=32 monitor with butterfly RAM model ----
  always @(negedge clk) begin
    if (mon_on) begin
      if (!if32.busy) begin
        c32_rd = 0;
        c32_wr = 0;
        p_sr.delete(); p_si.delete(); p_dr.delete(); p_di.delete();
      end
      if (if32.rd_en) begin
        c32_rd++;
        m_ang = 2.0 * 3.14159265358979 * real'(int'(if32.twiddle_idx)) / 32.0;
        m_wr  = $cos(m_ang);
        m_wi  = -$sin(m_ang);
        m_tr  = m_wr * re[if32.rd_addr_b] - m_wi * im[if32.rd_addr_b];
        m_ti  = m_wr * im[if32.rd_addr_b] + m_wi * re[if32.rd_addr_b];
        p_sr.push_back(re[if32.rd_addr_a] + m_tr);
        p_si.push_back(im[if32.rd_addr_a] + m_ti);
        p_dr.push_back(re[if32.rd_addr_a] - m_tr);
        p_di.push_back(im[if32.rd_addr_a] - m_ti);
      end
      if (if32.wr_en) begin
        c32_wr++;
        if (p_sr.size() == 0) chk("d32_wr_unexpected", cyc, -1);
        else begin
          re[if32.wr_addr_a] = p_sr.pop_front();
          im[if32.wr_addr_a] = p_si.pop_front();
          re[if32.wr_addr_b] = p_dr.pop_front();
          im[if32.wr_addr_b] = p_di.pop_front();
        end
      end
      if (if32.done) begin
        if (q32_done.size() == 0) chk("d32_done_unexpected", cyc, -1);
        else begin
          chk("d32_done_cycle", cyc, q32_done.pop_front());
          chk("d32_rd_count", c32_rd, 80);
          chk("d32_wr_count", c32_wr, 80);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    if8.start  = 1'b0;
    if8.abort  = 1'b0;
    if32.start = 1'b0;
    if32.abort = 1'b0;
    ram_impulse();

    rst_n = 1'b0;
    tick(3);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("d8_outs_reset", int'({if8.busy, if8.done, if8.stage, if8.rd_en, if8.rd_addr_a,
        if8.rd_addr_b, if8.twiddle_idx, if8.wr_en, if8.wr_addr_a, if8.wr_addr_b}), 0);
    chk("d32_outs_reset", int'({if32.busy, if32.done, if32.stage, if32.rd_en, if32.rd_addr_a,
        if32.rd_addr_b, if32.twiddle_idx, if32.wr_en, if32.wr_addr_a, if32.wr_addr_b}), 0);

    // N=8 directed run
    tick(1);
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      q8_rd.push_back('{cyc: c0 + t8_off[i], addr: pack(t8_a[i], t8_b[i], t8_tw[i], i / 4)});
      q8_wr.push_back('{cyc: c0 + t8_off[i] + 3, addr: pack(t8_a[i], t8_b[i], 0, 0)});
    end
    q8_done.push_back(c0 + 22);
    if8.start = 1'b1;
    tick(1);
    if8.start = 1'b0;
    tick_to(c0 + 30);
    chk("d8_rd_left", q8_rd.size(), 0);
    chk("d8_wr_left", q8_wr.size(), 0);
    chk("d8_done_left", q8_done.size(), 0);

    // start and abort together while idle
    if8.start = 1'b1;
    if8.abort = 1'b1;
    tick(1);
    if8.start = 1'b0;
    if8.abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("d8_busy_after_start_abort", int'(if8.busy), 0);
    end

    // N=32 impulse, starts while busy ignored, restart right after DONE
    tick(1);
    c0 = cyc;
    ram_impulse();
    q32_done.push_back(c0 + 96);
    q32_done.push_back(c0 + 193);
    for (int rel = 0; rel <= 200; rel++) begin
      tick_to(c0 + rel);
      if32.start = (rel == 0 || rel == 5 || rel == 50 || rel == 96 || rel == 97);
      if (rel == 97) check_bins();
    end
    if32.start = 1'b0;
    tick_to(c0 + 205);
    chk("d32_done_left_run2", q32_done.size(), 0);

    // abort in stage 1
    c0 = cyc;
    if32.start = 1'b1;
    tick(1);
    if32.start = 1'b0;
    tick_to(c0 + 30);
    chk("d32_stage_at_abort", int'(if32.stage), 1);
    if32.abort = 1'b1;
    tick(1);
    if32.abort = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("d32_quiet_after_abort", int'({if32.busy, if32.rd_en, if32.wr_en, if32.done}), 0);
    end

    // restart after abort
    tick(1);
    c0 = cyc;
    q32_done.push_back(c0 + 96);
    if32.start = 1'b1;
    tick(1);
    if32.start = 1'b0;
    tick_to(c0 + 100);
    chk("d32_done_left_restart", q32_done.size(), 0);

    // reset pulse mid-transform
    c0 = cyc;
    if32.start = 1'b1;
    tick(1);
    if32.start = 1'b0;
    tick_to(c0 + 40);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("d32_outs_after_rst", int'({if32.busy, if32.done, if32.stage, if32.rd_en, if32.rd_addr_a,
        if32.rd_addr_b, if32.twiddle_idx, if32.wr_en, if32.wr_addr_a, if32.wr_addr_b}), 0);
    repeat (5) @(negedge clk);
    chk("d32_idle_after_rst", int'(if32.busy), 0);
    chk("d32_done_left_final", q32_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
